// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU two-requester arbiter: op encoding, FSM states,
// and the request bundle captured on acceptance.
package tinyalu_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4,
    rst_op = 3'd7
  } operation_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  // Only these codes reach the ALU; everything else is answered locally.
  function automatic logic is_alu_op(logic [2:0] op);
    return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
  endfunction

endpackage

// File: rtl/tinyalu_rr_grant.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the requester
// that was not granted last. Output is always one-hot.
module tinyalu_rr_grant (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  logic pick;

  always_comb begin
    pick = ~last;
    if (valid[0] && !valid[1])      pick = 1'b0;
    else if (valid[1] && !valid[0]) pick = 1'b1;
    grant = 2'b01 << pick;
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Round-robin front end for a single TinyALU: accepts one op at a time from two
// requesters, issues it, and returns a one-cycle response to the owner.
module tinyalu_arbiter
  import tinyalu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_A,
  input  logic [7:0]  req0_B,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_A,
  input  logic [7:0]  req1_B,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_result,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_result,
  output logic        rsp1_err,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  input  logic        alu_done,
  input  logic [15:0] alu_result
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t                     state;
  logic                           last;
  logic                           owner;
  logic [CW-1:0]                  cnt;
  logic [NUM_REQ-1:0]             valid;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             ready;
  req_t [NUM_REQ-1:0]             req;
  req_t                           sel;
  logic                           idx;
  logic                           accept;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [NUM_REQ-1:0][15:0]       rsp_result;
  logic [NUM_REQ-1:0]             rsp_err;

  assign valid  = {req1_valid, req0_valid};
  assign req[0] = {req0_op, req0_A, req0_B};
  assign req[1] = {req1_op, req1_A, req1_B};

  tinyalu_rr_grant u_grant (
    .valid (valid),
    .last  (last),
    .grant (grant)
  );

  // reset_n gates ready so nothing looks acceptable while reset is held.
  assign ready  = (state == IDLE && reset_n) ? (grant & valid) : '0;
  assign accept = |ready;
  assign idx    = grant[1];
  assign sel    = req[idx];

  assign req0_ready  = ready[0];
  assign req1_ready  = ready[1];
  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_result = rsp_result[0];
  assign rsp1_result = rsp_result[1];
  assign rsp0_err    = rsp_err[0];
  assign rsp1_err    = rsp_err[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_err    <= '0;
    end else begin
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_err    <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            last  <= idx;
            owner <= idx;
            cnt   <= '0;
            if (is_alu_op(sel.op)) begin
              state     <= ISSUE;
              alu_start <= 1'b1;
              alu_op    <= sel.op;
              alu_A     <= sel.a;
              alu_B     <= sel.b;
            end else begin
              state          <= RESP;
              rsp_valid[idx] <= 1'b1;
              rsp_err[idx]   <= (sel.op != no_op);
            end
          end
        end
        ISSUE: begin
          if (alu_done || cnt == CW'(TIMEOUT - 1)) begin
            state             <= RESP;
            alu_start         <= 1'b0;
            alu_op            <= '0;
            alu_A             <= '0;
            alu_B             <= '0;
            rsp_valid[owner]  <= 1'b1;
            rsp_result[owner] <= alu_done ? alu_result : 16'h0000;
            rsp_err[owner]    <= ~alu_done;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter: a per-cycle protocol model checks every
// output each cycle, and each scenario then pins logged results to literals.
module tb_tinyalu_arbiter;
  import tinyalu_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [15:0] rsp0_result, rsp1_result;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_A, alu_B;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;

  always #5 clk = ~clk;

  tinyalu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
    .alu_start(alu_start), .alu_op(alu_op), .alu_A(alu_A), .alu_B(alu_B),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_f(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // ALU stand-in: done in the 1st start cycle (3rd for mul), never when hung.
  bit hang = 1'b0;
  int k = 0;
  always @(posedge clk) begin
    #2;
    if (alu_start) begin
      k++;
      if (!hang && k == ((alu_op == 3'd4) ? 3 : 1)) begin
        alu_done   = 1'b1;
        alu_result = alu_f(alu_op, alu_A, alu_B);
      end else begin
        alu_done   = 1'b0;
        alu_result = 16'hBAD0;
      end
    end else begin
      k          = 0;
      alu_done   = 1'b0;
      alu_result = 16'hBAD0;
    end
  end

  // Requester drivers: each queue head is held valid until the handshake fires.
  req_t q0[$], q1[$];
  bit   fire0, fire1;
  always @(posedge clk) begin
    #1;
    if (fire0 && q0.size() > 0) void'(q0.pop_front());
    if (fire1 && q1.size() > 0) void'(q1.pop_front());
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    {req0_op, req0_A, req0_B} = req0_valid ? q0[0] : '0;
    {req1_op, req1_A, req1_B} = req1_valid ? q1[0] : '0;
  end

  // Protocol model and per-cycle compare.
  typedef enum int {M_FREE, M_ALU, M_RESP} mode_t;
  mode_t       mode = M_FREE;
  logic        mlast = 1'b1, mown = 1'b0, merr = 1'b0;
  req_t        mreq = '0;
  logic [15:0] mres = '0;
  int          n = 0;
  int          start_cnt = 0;
  int          acc_id[$], acc_cyc[$], rsp_id[$], rsp_cyc[$];
  logic [15:0] rsp_res[$];
  logic        rsp_err[$];

  always @(negedge clk) begin
    logic [1:0]  v, er;
    logic        w, es, e0v, e1v, e0e, e1e;
    logic [2:0]  eop;
    logic [7:0]  ea, eb;
    logic [15:0] e0r, e1r;
    logic [57:0] act, exp;
    fire0 = req0_valid & req0_ready;
    fire1 = req1_valid & req1_ready;
    er = '0; es = 0; eop = '0; ea = '0; eb = '0;
    e0v = 0; e1v = 0; e0e = 0; e1e = 0; e0r = '0; e1r = '0;
    if (!reset_n) begin
      mode = M_FREE; mlast = 1'b1;
    end else begin
      case (mode)
        M_FREE: begin
          v = {req1_valid, req0_valid};
          if (v == 2'b11)  w = ~mlast;
          else if (v[1])   w = 1'b1;
          else if (v[0])   w = 1'b0;
          else             w = ~mlast;
          if (v[w]) begin
            er[w] = 1'b1;
            mlast = w; mown = w;
            mreq  = w ? req_t'({req1_op, req1_A, req1_B}) : req_t'({req0_op, req0_A, req0_B});
            acc_id.push_back(int'(w)); acc_cyc.push_back(cyc);
            if (mreq.op >= 3'd1 && mreq.op <= 3'd4) begin
              mode = M_ALU; n = 0;
            end else begin
              mode = M_RESP; mres = '0; merr = (mreq.op != 3'd0);
            end
          end
        end
        M_ALU: begin
          es = 1; eop = mreq.op; ea = mreq.a; eb = mreq.b;
          n++; start_cnt++;
          if (alu_done) begin
            mode = M_RESP; mres = alu_f(mreq.op, mreq.a, mreq.b); merr = 0;
          end else if (n == TIMEOUT) begin
            mode = M_RESP; mres = '0; merr = 1;
          end
        end
        default: begin
          if (mown) begin e1v = 1; e1r = mres; e1e = merr; end
          else      begin e0v = 1; e0r = mres; e0e = merr; end
          rsp_id.push_back(int'(mown)); rsp_res.push_back(mres);
          rsp_err.push_back(merr); rsp_cyc.push_back(cyc);
          mode = M_FREE;
        end
      endcase
    end
    act = {req1_ready, req0_ready, alu_start, alu_op, alu_A, alu_B,
           rsp0_valid, rsp0_result, rsp0_err, rsp1_valid, rsp1_result, rsp1_err};
    exp = {er, es, eop, ea, eb, e0v, e0r, e0e, e1v, e1r, e1e};
    chk($sformatf("cycle %0d outputs", cyc), 64'(act), 64'(exp));
  end

  task automatic clear_logs();
    acc_id.delete(); acc_cyc.delete(); rsp_id.delete(); rsp_cyc.delete();
    rsp_res.delete(); rsp_err.delete(); start_cnt = 0;
  endtask

  task automatic wait_quiet(string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && mode == M_FREE && !req0_valid && !req1_valid) break;
    end
    if (i == 300) chk({name, " drain timeout"}, 64'(i), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset_n = 1'b0;
    q0.delete(); q1.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    // Reset state, with a request already waiting on req0.
    q0.push_back({3'd1, 8'h12, 8'h34});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset readys", 64'({req1_ready, req0_ready}), 64'(0));
    chk("reset alu_start", 64'(alu_start), 64'(0));
    chk("reset pointer", 64'(dut.last), 64'(1));
    release_reset();

    // add 12+34 from req0
    wait_quiet("add");
    chk("add rsp count", 64'(rsp_id.size()), 64'(1));
    chk("add rsp id", 64'(rsp_id[0]), 64'(0));
    chk("add result", 64'(rsp_res[0]), 64'h0046);
    chk("add err", 64'(rsp_err[0]), 64'(0));
    chk("add latency", 64'(rsp_cyc[0] - acc_cyc[0]), 64'(2));
    chk("add start cycles", 64'(start_cnt), 64'(1));

    // Tie straight after reset: req0 mul, req1 xor
    do_reset();
    clear_logs();
    q0.push_back({3'd4, 8'hFF, 8'hFF});
    q1.push_back({3'd3, 8'hF0, 8'h0F});
    release_reset();
    wait_quiet("tie");
    chk("tie rsp count", 64'(rsp_id.size()), 64'(2));
    chk("tie first id", 64'(rsp_id[0]), 64'(0));
    chk("tie mul result", 64'(rsp_res[0]), 64'hFE01);
    chk("tie second id", 64'(rsp_id[1]), 64'(1));
    chk("tie xor result", 64'(rsp_res[1]), 64'h00FF);
    chk("tie start cycles", 64'(start_cnt), 64'(4));

    // Six back-to-back ops with both requesters always valid
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      q0.push_back({3'd1, 8'(i), 8'h10});
      q1.push_back({3'd2, 8'hF0, 8'(8'h3C + i)});
    end
    wait_quiet("alternate");
    chk("alternate count", 64'(acc_id.size()), 64'(6));
    for (int i = 0; i < 6; i++)
      chk($sformatf("alternate grant %0d", i), 64'(acc_id[i]), 64'(i % 2));
    chk("alternate and result", 64'(rsp_res[1]), 64'h0030);

    // Locally answered error ops on req1
    clear_logs();
    q1.push_back({3'd7, 8'hAA, 8'h55});
    q1.push_back({3'd5, 8'h01, 8'h02});
    wait_quiet("errop");
    chk("errop rsp count", 64'(rsp_id.size()), 64'(2));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("errop %0d id", i), 64'(rsp_id[i]), 64'(1));
      chk($sformatf("errop %0d err", i), 64'(rsp_err[i]), 64'(1));
      chk($sformatf("errop %0d result", i), 64'(rsp_res[i]), 64'(0));
      chk($sformatf("errop %0d latency", i), 64'(rsp_cyc[i] - acc_cyc[i]), 64'(1));
    end
    chk("errop start cycles", 64'(start_cnt), 64'(0));

    // Timeout with alu_done held low, then a normal op
    clear_logs();
    hang = 1'b1;
    q0.push_back({3'd1, 8'h01, 8'h02});
    wait_quiet("timeout");
    chk("timeout start cycles", 64'(start_cnt), 64'(TIMEOUT));
    chk("timeout err", 64'(rsp_err[0]), 64'(1));
    chk("timeout result", 64'(rsp_res[0]), 64'(0));
    hang = 1'b0;
    clear_logs();
    q0.push_back({3'd1, 8'h03, 8'h04});
    wait_quiet("post timeout");
    chk("post timeout result", 64'(rsp_res[0]), 64'h0007);
    chk("post timeout err", 64'(rsp_err[0]), 64'(0));

    // Reset in the middle of a mul, then req1 alone
    clear_logs();
    q0.push_back({3'd4, 8'h05, 8'h06});
    for (int i = 0; i < 50 && !alu_start; i++) @(negedge clk);
    chk("abort start seen", 64'(alu_start), 64'(1));
    do_reset();
    #1;
    chk("abort outputs", 64'({alu_start, alu_op, alu_A, alu_B, rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 64'(0));
    q1.push_back({3'd1, 8'h20, 8'h22});
    release_reset();
    wait_quiet("abort");
    chk("abort rsp count", 64'(rsp_id.size()), 64'(1));
    chk("abort rsp id", 64'(rsp_id[0]), 64'(1));
    chk("abort rsp result", 64'(rsp_res[0]), 64'h0042);
    chk("abort grant", 64'(acc_id[acc_id.size() - 1]), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
